// File: rtl/traffic_phase_ctrl.sv
// Fixed-cycle six-movement traffic phase controller: GREEN -> YELLOW -> CLEAR per
// movement, stepped by a 1 s tick derived from sys_clk, with a freeze input.
module traffic_phase_ctrl #(
    parameter int CLK_DIV      = 50_000_000,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [5:0] ew_left_time,
    input  logic [5:0] ew_stra_time,
    input  logic [5:0] ew_right_time,
    input  logic [5:0] sn_left_time,
    input  logic [5:0] sn_stra_time,
    input  logic [5:0] sn_right_time,
    input  logic       hold,
    output logic [5:0] green,
    output logic [5:0] yellow,
    output logic [5:0] red,
    output logic [5:0] countdown,
    output logic [2:0] phase,
    output logic       phase_start
);

    localparam int PRE_W = $clog2(CLK_DIV);

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_CLEAR  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [2:0]       phase_q, phase_d;
    logic [2:0]       phase_nx;
    logic [5:0]       cnt_q, cnt_d;
    logic [5:0]       green_time;
    logic [5:0]       mask;
    logic             pstart_q, pstart_d;
    logic             tick;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pre_q    <= '0;
            state_q  <= ST_CLEAR;
            phase_q  <= 3'd5;
            cnt_q    <= 6'(ALL_RED_TIME);
            pstart_q <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            pstart_q <= pstart_d;
        end
    end

    always_comb begin
        tick       = 1'b0;
        pre_d      = pre_q;
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        pstart_d   = 1'b0;
        phase_nx   = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
        green_time = sn_right_time;

        // Prescaler is frozen entirely while hold is high, so timing resumes exactly.
        if (!hold) begin
            if (pre_q == PRE_W'(CLK_DIV - 1)) begin
                pre_d = '0;
                tick  = 1'b1;
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end

        case (phase_nx)
            3'd0:    green_time = ew_left_time;
            3'd1:    green_time = ew_stra_time;
            3'd2:    green_time = ew_right_time;
            3'd3:    green_time = sn_left_time;
            3'd4:    green_time = sn_stra_time;
            default: green_time = sn_right_time;
        endcase

        if (tick) begin
            if (cnt_q > 6'd1) begin
                cnt_d = cnt_q - 6'd1;
            end else begin
                case (state_q)
                    ST_GREEN: begin
                        state_d = ST_YELLOW;
                        cnt_d   = 6'(YELLOW_TIME);
                    end
                    ST_YELLOW: begin
                        state_d = ST_CLEAR;
                        cnt_d   = 6'(ALL_RED_TIME);
                    end
                    default: begin
                        // A zero green time still yields one tick so cnt never reaches 0.
                        state_d  = ST_GREEN;
                        phase_d  = phase_nx;
                        cnt_d    = (green_time == 6'd0) ? 6'd1 : green_time;
                        pstart_d = 1'b1;
                    end
                endcase
            end
        end

        // Lamp outputs decode only registered state; bit 5 is movement 0.
        mask   = 6'b100000 >> phase_q;
        green  = 6'h00;
        yellow = 6'h00;
        red    = 6'h3F;
        case (state_q)
            ST_GREEN: begin
                green = mask;
                red   = ~mask;
            end
            ST_YELLOW: begin
                yellow = mask;
                red    = ~mask;
            end
            default: ;
        endcase
    end

    assign countdown   = cnt_q;
    assign phase       = phase_q;
    assign phase_start = pstart_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: directed scenarios plus randomized
// green times, hold and reset, compared every cycle against a timeline model.
module tb_traffic_phase_ctrl;

    localparam int CLK_DIV = 4;
    localparam int YT      = 3;
    localparam int ART     = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       hold;
    logic [5:0] t [6];
    logic [5:0] green, yellow, red, countdown;
    logic [2:0] phase;
    logic       phase_start;

    int n_asrt = 0;
    int n_fail = 0;

    // Model: the current segment is (kind, phase, duration) with elapsed ticks;
    // kind 0 = green, 1 = yellow, 2 = all-red clearance.
    int m_pre, m_kind, m_phase, m_dur, m_el;
    bit m_ps;

    always #5 clk = ~clk;

    traffic_phase_ctrl #(
        .CLK_DIV(CLK_DIV), .YELLOW_TIME(YT), .ALL_RED_TIME(ART)
    ) dut (
        .sys_clk(clk), .sys_rst(rst),
        .ew_left_time(t[0]), .ew_stra_time(t[1]), .ew_right_time(t[2]),
        .sn_left_time(t[3]), .sn_stra_time(t[4]), .sn_right_time(t[5]),
        .hold(hold),
        .green(green), .yellow(yellow), .red(red), .countdown(countdown),
        .phase(phase), .phase_start(phase_start)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int gt;
        if (rst) begin
            m_pre = 0; m_kind = 2; m_phase = 5; m_dur = ART; m_el = 0; m_ps = 0;
            return;
        end
        m_ps = 0;
        if (hold) return;
        if (m_pre != CLK_DIV - 1) begin
            m_pre++;
            return;
        end
        m_pre = 0;
        m_el++;
        if (m_el < m_dur) return;
        m_el = 0;
        if (m_kind == 0) begin
            m_kind = 1; m_dur = YT;
        end else if (m_kind == 1) begin
            m_kind = 2; m_dur = ART;
        end else begin
            m_kind  = 0;
            m_phase = (m_phase + 1) % 6;
            gt      = int'(t[m_phase]);
            m_dur   = (gt < 1) ? 1 : gt;
            m_ps    = 1;
        end
    endtask

    task automatic compare_all();
        logic [5:0] eg, ey, er;
        eg = '0; ey = '0; er = '0;
        for (int b = 0; b < 6; b++) begin
            if ((5 - b) == m_phase && m_kind == 0)      eg[b] = 1'b1;
            else if ((5 - b) == m_phase && m_kind == 1) ey[b] = 1'b1;
            else                                        er[b] = 1'b1;
        end
        chk("green", 32'(green), 32'(eg));
        chk("yellow", 32'(yellow), 32'(ey));
        chk("red", 32'(red), 32'(er));
        chk("countdown", 32'(countdown), 32'(m_dur - m_el));
        chk("phase", 32'(phase), 32'(m_phase));
        chk("phase_start", 32'(phase_start), 32'(m_ps));
        chk("lamp_cover", 32'(green | yellow | red), 32'h3F);
        chk("lamp_excl", 32'((green & yellow) | (green & red) | (yellow & red)), 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until the model sits in the requested segment (-1 = don't care).
    task automatic wait_for(input string tag, input int kind, input int ph, input int cd,
                            input int budget);
        bit found;
        found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            step();
            if ((kind < 0 || m_kind == kind) && (ph < 0 || m_phase == ph) &&
                (cd < 0 || (m_dur - m_el) == cd))
                found = 1;
        end
        chk({"reach_", tag}, 32'(found), 32'd1);
    endtask

    initial begin
        int red_cycles;
        rst  = 1'b1;
        hold = 1'b0;
        for (int i = 0; i < 6; i++) t[i] = 6'd5;

        // Reset state
        run(2);
        chk("rst_red", 32'(red), 32'h3F);
        chk("rst_countdown", 32'(countdown), 32'(ART));
        chk("rst_phase", 32'(phase), 32'd5);
        rst = 1'b0;

        // First green appears CLK_DIV cycles after release
        red_cycles = 0;
        for (int i = 0; i < 10 && green == 6'h00; i++) begin
            step();
            if (green == 6'h00) red_cycles++;
        end
        chk("first_green_delay", 32'(red_cycles), 32'(CLK_DIV - 1));
        chk("first_green", 32'(green), 32'b100000);
        chk("first_countdown", 32'(countdown), 32'd5);
        chk("first_pstart", 32'(phase_start), 32'd1);
        step();
        chk("pstart_one_cycle", 32'(phase_start), 32'd0);

        // Full rotation: back to phase 0 green after 216 cycles
        run(215);
        chk("wrap_phase", 32'(phase), 32'd0);
        chk("wrap_green", 32'(green), 32'b100000);
        chk("wrap_pstart", 32'(phase_start), 32'd1);

        // Lengthen phase 0 mid-green: applies only to the next phase-0 green
        wait_for("p0_mid", 0, 0, 3, 400);
        t[0] = 6'd20;
        wait_for("p0_next", 0, 0, 20, 400);
        chk("p0_long_countdown", 32'(countdown), 32'd20);
        t[0] = 6'd5;

        // Zero green time for phase 5 behaves as one tick
        t[5] = 6'd0;
        wait_for("p5_green", 0, 5, -1, 600);
        chk("p5_countdown", 32'(countdown), 32'd1);
        wait_for("p5_yellow", 1, 5, -1, 40);
        chk("p5_yellow_cd", 32'(countdown), 32'(YT));
        t[5] = 6'd5;

        // Hold mid-yellow at countdown 2, one cycle into the tick period
        wait_for("hold_pt", 1, -1, 2, 600);
        step();
        hold = 1'b1;
        run(100);
        chk("hold_countdown", 32'(countdown), 32'd2);
        hold = 1'b0;
        wait_for("after_hold", 2, -1, -1, 40);

        // Reset pulse in phase 2 green
        wait_for("p2_green", 0, 2, -1, 600);
        run(2);
        rst = 1'b1;
        step();
        chk("midrst_red", 32'(red), 32'h3F);
        chk("midrst_phase", 32'(phase), 32'd5);
        chk("midrst_cd", 32'(countdown), 32'd1);
        rst = 1'b0;
        run(4);
        chk("midrst_p0", 32'(green), 32'b100000);

        // Randomized green times, hold and occasional reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) t[$urandom_range(0, 5)] = 6'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) hold = ~hold;
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst  = 1'b0;
        hold = 1'b0;
        run(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
